// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES shared S-boxes substitute a WIDTH-bit state over WIDTH/(8*LANES) beats.
// Optional macro AES_INV_SBOX_EN adds inv_i and an inverse S-box path in every lane.

module sub_bytes_lane (
  input  logic [7:0] in_i,
`ifdef AES_INV_SBOX_EN
  input  logic       inv_i,
`endif
  output logic [7:0] out_o
);
  // Forward table, entry 0 in the top byte.
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [7:0] fwd;
  assign fwd = FWD[{~in_i, 3'b000} +: 8];

`ifdef AES_INV_SBOX_EN
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // x^254 via square-and-multiply: the GF(2^8) inverse, 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  logic [7:0] aff;
  assign aff   = rotl(in_i, 1) ^ rotl(in_i, 3) ^ rotl(in_i, 6) ^ 8'h05;
  assign out_o = inv_i ? ginv(aff) : fwd;
`else
  assign out_o = fwd;
`endif
endmodule

module sub_bytes_iter #(
  parameter int WIDTH = 128,
  parameter int LANES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef AES_INV_SBOX_EN
  input  logic             inv_i,
`endif
  output logic             in_ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);
  localparam int LW     = 8 * LANES;
  localparam int NBEATS = WIDTH / LW;
  localparam int CW     = $clog2(NBEATS) + 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
        (WIDTH % LW) != 0 || WIDTH < LW) begin : g_bad_cfg
      $error("sub_bytes_iter: illegal WIDTH/LANES combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q;
  logic             valid_q, busy_q, in_ready_q;
  logic [LW-1:0]    sub;
`ifdef AES_INV_SBOX_EN
  logic             inv_q;
`endif

  // Lane l substitutes byte l of the top group and writes it back in the same position.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_bytes_lane u_lane (
      .in_i  (shift_q[WIDTH-1-8*l -: 8]),
`ifdef AES_INV_SBOX_EN
      .inv_i (inv_q),
`endif
      .out_o (sub[LW-1-8*l -: 8])
    );
  end

  assign shift_d = (shift_q << LW) | WIDTH'(sub);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef AES_INV_SBOX_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q    <= RUN;
          shift_q    <= data_i;
          cnt_q      <= '0;
          busy_q     <= 1'b1;
          in_ready_q <= 1'b0;
`ifdef AES_INV_SBOX_EN
          inv_q      <= inv_i;
`endif
        end
        RUN: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NBEATS - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: if (ready_i) begin
          state_q    <= IDLE;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o     = shift_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign in_ready_o = in_ready_q;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: directed vectors, LANES sweep, backpressure, reset, random blocks vs. GF(2^8) model.
module tb_sub_bytes_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, ready, valid, in_ready, busy;
  logic [127:0] din, dout;
`ifdef AES_INV_SBOX_EN
  logic         inv;
`endif

  sub_bytes_iter #(.WIDTH(128), .LANES(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(din),
`ifdef AES_INV_SBOX_EN
    .inv_i(inv),
`endif
    .in_ready_o(in_ready), .valid_o(valid), .ready_i(ready), .data_o(dout), .busy_o(busy));

  logic         sw_start, sw_ready;
  logic [127:0] sw_din;
  logic         sw_valid[5], sw_inr[5], sw_busy[5];
  logic [127:0] sw_dout[5];

  for (genvar g = 0; g < 5; g++) begin : g_sw
    sub_bytes_iter #(.WIDTH(128), .LANES(1 << g)) u_sw (
      .clk_i(clk), .rst_i(rst), .start_i(sw_start), .data_i(sw_din),
`ifdef AES_INV_SBOX_EN
      .inv_i(1'b0),
`endif
      .in_ready_o(sw_inr[g]), .valid_o(sw_valid[g]), .ready_i(sw_ready),
      .data_o(sw_dout[g]), .busy_o(sw_busy[g]));
  end

  int total = 0, bad = 0, xfers = 0;
  logic [7:0] sb[256], isb[256];

  typedef struct { logic [127:0] din; logic [127:0] dout; } vec_t;
  vec_t vecs[4];

  // Carry-less product reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] y = 8'h00;
      for (int c = 1; c < 256; c++) if (gf_mul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      sb[x] = y ^ rol(y, 1) ^ rol(y, 2) ^ rol(y, 3) ^ rol(y, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input bit iv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = iv ? isb[d[127-8*i -: 8]] : sb[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start_block(input logic [127:0] d, input bit iv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
    start = 1'b1;
    din   = d;
`ifdef AES_INV_SBOX_EN
    inv = iv;
`else
    if (iv) $display("note: inverse mode requested in a forward-only build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
    din   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts edges from accept until valid_o; pokes start_i and inv_i while busy.
  task automatic wait_valid(output int lat, input bit poke);
    lat = 0;
    while (!valid && lat < 40) begin
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        din   = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SBOX_EN
        inv = 1'($urandom_range(0, 1));
`endif
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic release_ready(input string nm);
    bit was_valid;
    @(negedge clk);
    was_valid = valid;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk({nm, "_idle"}, {125'd0, in_ready, valid, busy}, 128'b100);
    if (was_valid && in_ready) xfers++;
  endtask

  initial begin
    int lat, seen[5];
    logic [127:0] d, exp;
    bit iv;
    build_tables();
    vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[2] = '{{16{8'h00}}, {16{8'h63}}};
    vecs[3] = '{{16{8'hff}}, {16{8'h16}}};

    rst = 1'b1; start = 1'b0; ready = 1'b0; din = '0;
    sw_start = 1'b0; sw_ready = 1'b0; sw_din = '0;
`ifdef AES_INV_SBOX_EN
    inv = 1'b0;
`endif
    #12;
    chk("reset_flags", {125'd0, in_ready, valid, busy}, 128'b100);
    chk("reset_data", dout, 128'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      start_block(vecs[i].din, 1'b0);
      wait_valid(lat, 1'b0);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd4);
      chk($sformatf("vec%0d_data", i), dout, vecs[i].dout);
      release_ready($sformatf("vec%0d", i));
    end

    // Backpressure: DONE held for 10 cycles with stray start pulses.
    d = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_sub(d, 1'b0);
    start_block(d, 1'b0);
    wait_valid(lat, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b1;
      din   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_data", dout, exp);
      chk("bp_flags", {125'd0, in_ready, valid, busy}, 128'b011);
    end
    release_ready("bp");

    // Reset in the middle of RUN (cnt==2), observed before the next edge.
    start_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_flags", {125'd0, in_ready, valid, busy}, 128'b100);
    chk("midrun_rst_data", dout, 128'd0);
    @(negedge clk); rst = 1'b0;
    start_block(vecs[1].din, 1'b0);
    wait_valid(lat, 1'b0);
    chk("post_rst_lat", 128'(lat), 128'd4);
    chk("post_rst_data", dout, vecs[1].dout);
    release_ready("post_rst");

    // LANES sweep on all-00 and all-ff.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      sw_start = 1'b1;
      sw_din   = p ? {16{8'hff}} : {16{8'h00}};
      exp      = p ? {16{8'h16}} : {16{8'h63}};
      @(posedge clk); #1;
      sw_start = 1'b0;
      for (int g = 0; g < 5; g++) seen[g] = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        for (int g = 0; g < 5; g++) if (sw_valid[g] && seen[g] == 0) seen[g] = k;
      end
      for (int g = 0; g < 5; g++) begin
        chk($sformatf("sweep_l%0d_lat", 1 << g), 128'(seen[g]), 128'(16 >> g));
        chk($sformatf("sweep_l%0d_data", 1 << g), sw_dout[g], exp);
      end
      @(negedge clk); sw_ready = 1'b1;
      @(posedge clk); #1; sw_ready = 1'b0;
      for (int g = 0; g < 5; g++)
        chk($sformatf("sweep_l%0d_idle", 1 << g), {125'd0, sw_inr[g], sw_valid[g], sw_busy[g]}, 128'b100);
    end

`ifdef AES_INV_SBOX_EN
    // Inverse mode, inv_i wiggled during RUN.
    start_block(vecs[0].dout, 1'b1);
    wait_valid(lat, 1'b1);
    chk("inv_lat", 128'(lat), 128'd4);
    chk("inv_data", dout, vecs[0].din);
    release_ready("inv");
`endif

    // Random blocks with gaps, stray starts and ready stalls.
    xfers = 0;
    for (int b = 0; b < 1000; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SBOX_EN
      iv = 1'($urandom_range(0, 1));
`else
      iv = 1'b0;
`endif
      exp = ref_sub(d, iv);
      start_block(d, iv);
      wait_valid(lat, 1'b1);
      chk("rnd_lat", 128'(lat), 128'd4);
      chk("rnd_data", dout, exp);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_stall", {dout, valid}, {exp, 1'b1});
      end
      release_ready("rnd");
    end
    chk("rnd_xfer_count", 128'(xfers), 128'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
